// File: rtl/spi_config_pkg.sv
// Shared configuration for the SPI slave: word length, SPI mode encoding and FSM states.
// Mode numbering follows the usual {CPOL, CPHA} convention.
package spi_config_pkg;

  localparam int BIT_WIDTH = 32;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode;

  typedef enum logic [1:0] {
    SLV_IDLE  = 2'd0,
    SLV_LOAD  = 2'd1,
    SLV_SHIFT = 2'd2,
    SLV_DONE  = 2'd3
  } spi_slave_states;

  function automatic logic mode_cpol(input spi_mode m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Parallel-side word stream of the SPI slave: tx holding-buffer handshake and rx word output.
interface spi_slave_if #(
  parameter int BIT_WIDTH = spi_config_pkg::BIT_WIDTH
);
  logic [BIT_WIDTH-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [BIT_WIDTH-1:0] rx_data;
  logic                 rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for a bundle of async pins, with rise/fall detect on the low EDGE_W bits.
// All bits share the same depth so data pins stay aligned with the clock pin.
module spi_sync_edge #(
  parameter int               SYNC_STAGES = 2,
  parameter int               WIDTH       = 3,
  parameter int               EDGE_W      = 1,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  async_in,
  output logic [WIDTH-1:0]  sync_out,
  output logic [EDGE_W-1:0] rise,
  output logic [EDGE_W-1:0] fall
);

  logic [WIDTH-1:0]  stage_q [SYNC_STAGES];
  logic [EDGE_W-1:0] dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
      dly_q <= RST_VAL[EDGE_W-1:0];
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      dly_q <= stage_q[SYNC_STAGES-1][EDGE_W-1:0];
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];
  assign rise     = sync_out[EDGE_W-1:0] & ~dly_q;
  assign fall     = ~sync_out[EDGE_W-1:0] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, MSB first, one-word tx holding buffer and oversampled SPI pins.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// SLV_IDLE  | deselected; waiting for cs_n to fall, mode latched on exit
// SLV_LOAD  | one cycle: holding buffer -> tx shifter (zeros + underrun if empty)
// SLV_SHIFT | counting sample edges, shifting mosi in and miso out
// SLV_DONE  | one cycle after the last sample; rx word published this cycle
module spi_slave #(
  parameter int BIT_WIDTH   = spi_config_pkg::BIT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  spi_config_pkg::spi_mode  mode,
  spi_slave_if.slave               bus,
  input  logic                     sclk,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  output logic                     busy,
  output logic                     underrun,
  output logic                     abort
);
  import spi_config_pkg::*;

  localparam int                CNT_W    = $clog2(BIT_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BIT_WIDTH - 1);

  // bundle order: [0] sclk, [1] cs_n, [2] mosi; edges wanted on sclk and cs_n
  logic [2:0] pins_sync;
  logic [1:0] pins_rise;
  logic [1:0] pins_fall;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (3),
    .EDGE_W      (2),
    .RST_VAL     (3'b010)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in ({mosi, cs_n, sclk}),
    .sync_out (pins_sync),
    .rise     (pins_rise),
    .fall     (pins_fall)
  );

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n_sync, mosi_sync;
  assign sclk_rise = pins_rise[0];
  assign sclk_fall = pins_fall[0];
  assign cs_rise   = pins_rise[1];
  assign cs_fall   = pins_fall[1];
  assign cs_n_sync = pins_sync[1];
  assign mosi_sync = pins_sync[2];

  spi_slave_states      state_q;
  logic                 cpol_q, cpha_q;
  logic [BIT_WIDTH-1:0] hold_q;
  logic                 hold_full_q;
  logic [BIT_WIDTH-1:0] tx_shift_q;
  logic [BIT_WIDTH-1:0] rx_shift_q;
  logic [BIT_WIDTH-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic [CNT_W-1:0]     bit_cnt_q;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic [BIT_WIDTH-1:0] rx_next;

  always_comb begin
    lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trail_edge : lead_edge;
    shift_edge  = cpha_q ? lead_edge : trail_edge;
  end

  assign rx_next = {rx_shift_q[BIT_WIDTH-2:0], mosi_sync};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SLV_IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_cnt_q   <= '0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
      abort       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun   <= 1'b0;
      abort      <= 1'b0;

      // a write only lands in an empty buffer, so it never collides with the LOAD drain
      if (bus.tx_valid && !hold_full_q) begin
        hold_q      <= bus.tx_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        SLV_IDLE: begin
          if (cs_fall) begin
            cpol_q  <= mode_cpol(mode);
            cpha_q  <= mode_cpha(mode);
            busy    <= 1'b1;
            state_q <= SLV_LOAD;
          end
        end

        SLV_LOAD: begin
          if (cs_rise) begin
            abort   <= 1'b1;
            busy    <= 1'b0;
            state_q <= SLV_IDLE;
          end else begin
            if (hold_full_q) begin
              tx_shift_q  <= hold_q;
              hold_full_q <= 1'b0;
            end else begin
              tx_shift_q <= '0;
              underrun   <= 1'b1;
            end
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            state_q    <= SLV_SHIFT;
          end
        end

        SLV_SHIFT: begin
          if (cs_rise) begin
            abort   <= 1'b1;
            busy    <= 1'b0;
            state_q <= SLV_IDLE;
          end else if (sample_edge) begin
            rx_shift_q <= rx_next;
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              state_q    <= SLV_DONE;
            end
          end else if (shift_edge && bit_cnt_q != '0) begin
            // the first shift edge of a word (and CPHA=0's trailing edge of the
            // previous word) only presents the MSB already sitting in the shifter
            tx_shift_q <= {tx_shift_q[BIT_WIDTH-2:0], 1'b0};
          end
        end

        SLV_DONE: begin
          if (!cs_n_sync) begin
            state_q <= SLV_LOAD;
          end else begin
            busy    <= 1'b0;
            state_q <= SLV_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          state_q <= SLV_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready = !hold_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  assign miso_oe = !cs_n_sync;
  assign miso    = miso_oe & tx_shift_q[BIT_WIDTH-1];

endmodule
